// File: rtl/nvram_upload_if.sv
// HPS ioctl upload handshake, game CPU pause pair and work-RAM read port grouped for nvram_upload.
interface nvram_upload_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              ioctl_upload;
    logic [7:0]        ioctl_index;
    logic              ioctl_rd;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic              pause_cpu;
    logic              pause_ack;
    logic              ram_rd;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_dout;

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, pause_ack, ram_dout,
        output ioctl_din, ioctl_wait, pause_cpu, ram_rd, ram_addr
    );

    modport master (
        output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, pause_ack, ram_dout,
        input  ioctl_din, ioctl_wait, pause_cpu, ram_rd, ram_addr
    );
endinterface

// File: rtl/nvram_upload.sv
// Answers HPS ioctl upload reads with bytes from a work-RAM window while the game CPU is paused.
// Optional NVRAM_UPLOAD_CHECKSUM_EN appends one XOR checksum byte at offset DATA_LEN.
module nvram_upload #(
    parameter logic [7:0]  INDEX    = 8'd4,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned BASE     = 0,
    parameter int unsigned DATA_LEN = 64,
    parameter int unsigned RAM_LAT  = 2
) (
    input  logic          clk_sys,
    input  logic          RESET,
    nvram_upload_if.slave bus
);
    localparam int unsigned CNT_W = 3;
    localparam int unsigned OFS_W = 25;
    localparam logic [OFS_W-1:0]  LEN_A  = OFS_W'(DATA_LEN);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
    localparam logic [CNT_W-1:0]  LAT_C  = CNT_W'(RAM_LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAUSE,
        S_READY,
        S_FETCH
    } state_t;

    state_t            r_state;
    state_t            w_state_n;
    logic              r_sel_d;
    logic              w_sel;
    logic              w_in_range;
    logic [7:0]        r_din;
    logic [7:0]        w_din_n;
    logic              r_wait;
    logic              w_wait_n;
    logic              r_pause;
    logic              w_pause_n;
    logic              r_ram_rd;
    logic              w_ram_rd_n;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [ADDR_W-1:0] w_ram_addr_n;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_n;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
    logic [7:0]        r_csum;
    logic [7:0]        w_csum_n;
`endif

    assign w_sel      = bus.ioctl_upload && (bus.ioctl_index == INDEX);
    assign w_in_range = bus.ioctl_addr < LEN_A;

    // Next state and next register values; losing sel overrides everything, even mid-fetch.
    always_comb begin
        w_state_n    = r_state;
        w_din_n      = r_din;
        w_ram_rd_n   = 1'b0;
        w_ram_addr_n = r_ram_addr;
        w_cnt_n      = r_cnt;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
        w_csum_n     = r_csum;
`endif
        if (!w_sel) begin
            w_state_n = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_sel_d) begin
                        w_state_n = S_PAUSE;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
                        w_csum_n  = 8'h00;
`endif
                    end
                end
                S_PAUSE: begin
                    if (bus.pause_ack) w_state_n = S_READY;
                end
                S_READY: begin
                    if (bus.ioctl_rd) begin
                        if (w_in_range) begin
                            w_state_n    = S_FETCH;
                            w_ram_addr_n = BASE_A + bus.ioctl_addr[ADDR_W-1:0];
                            w_ram_rd_n   = 1'b1;
                            w_cnt_n      = LAT_C;
                        end else begin
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
                            w_din_n = (bus.ioctl_addr == LEN_A) ? r_csum : 8'hFF;
`else
                            w_din_n = 8'hFF;
`endif
                        end
                    end
                end
                S_FETCH: begin
                    if (r_cnt == '0) begin
                        w_state_n = S_READY;
                        w_din_n   = bus.ram_dout;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
                        w_csum_n  = r_csum ^ bus.ram_dout;
`endif
                    end else begin
                        w_cnt_n = r_cnt - CNT_W'(1);
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
        // HPS is held off while the CPU is not yet halted and while a byte is in flight.
        w_wait_n  = (w_state_n == S_PAUSE) || (w_state_n == S_FETCH);
        w_pause_n = (w_state_n != S_IDLE);
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_sel_d    <= 1'b0;
            r_din      <= 8'h00;
            r_wait     <= 1'b0;
            r_pause    <= 1'b0;
            r_ram_rd   <= 1'b0;
            r_ram_addr <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_n;
            r_sel_d    <= w_sel;
            r_din      <= w_din_n;
            r_wait     <= w_wait_n;
            r_pause    <= w_pause_n;
            r_ram_rd   <= w_ram_rd_n;
            r_ram_addr <= w_ram_addr_n;
            r_cnt      <= w_cnt_n;
        end
    end

`ifdef NVRAM_UPLOAD_CHECKSUM_EN
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) r_csum <= 8'h00;
        else       r_csum <= w_csum_n;
    end
`endif

    assign bus.ioctl_din  = r_din;
    assign bus.ioctl_wait = r_wait;
    assign bus.pause_cpu  = r_pause;
    assign bus.ram_rd     = r_ram_rd;
    assign bus.ram_addr   = r_ram_addr;
endmodule
